// File: rtl/cpu_mdu_ctrl_pkg.sv
// rtl/cpu_mdu_ctrl_pkg.sv - MDU op codes, FSM states and op decode helpers
package cpu_mdu_ctrl_pkg;

  localparam logic [2:0] OP_CLASS_MDU = 3'b100;

  localparam logic [5:0] OP_MUL  = 6'h20;
  localparam logic [5:0] OP_DIVS = 6'h24;
  localparam logic [5:0] OP_MODS = 6'h25;
  localparam logic [5:0] OP_DIVU = 6'h26;
  localparam logic [5:0] OP_MODU = 6'h27;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [5:0] op);
    return op[5:3] == OP_CLASS_MDU;
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return is_mdu_op(op) && op[2];
  endfunction

endpackage

// File: rtl/cpu_mdu_ctrl_if.sv
// rtl/cpu_mdu_ctrl_if.sv - P3 issue / P4 result bundle between pipeline and MDU
interface cpu_mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             stall_in;
  logic [5:0]       p3_op;
  logic [WIDTH-1:0] p3_data_a;
  logic [WIDTH-1:0] p3_data_b;
  logic             mdu_stall;
  logic [WIDTH-1:0] p4_mdu_result;
  logic             p4_mdu_valid;
  logic             mdu_busy;

  modport master (
    output stall_in, p3_op, p3_data_a, p3_data_b,
    input  mdu_stall, p4_mdu_result, p4_mdu_valid, mdu_busy
  );

  modport slave (
    input  stall_in, p3_op, p3_data_a, p3_data_b,
    output mdu_stall, p4_mdu_result, p4_mdu_valid, mdu_busy
  );
endinterface

// File: rtl/cpu_divider_core.sv
// rtl/cpu_divider_core.sv - unsigned restoring divider datapath, one bit per step
module cpu_divider_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The quotient register starts as the dividend and is shifted out into
  // the remainder while the quotient bits are shifted in behind it.
  assign shifted = {remainder, quotient[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/cpu_mdu_ctrl.sv
// rtl/cpu_mdu_ctrl.sv - P3 multiply/divide sequencer with P4 result register
module cpu_mdu_ctrl
  import cpu_mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  cpu_mdu_ctrl_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state;
  logic [CW-1:0]    count;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             b_zero_q;
  logic             div_mod_q;
  logic [WIDTH-1:0] p4_result_q;
  logic             p4_valid_q;

  logic             op_is_mdu;
  logic             op_is_div;
  logic             op_is_mul;
  logic             op_signed;
  logic             op_mod;
  logic             issue;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] final_value;

  assign op_is_mdu = is_mdu_op(bus.p3_op);
  assign op_is_div = is_div_op(bus.p3_op);
  assign op_is_mul = bus.p3_op == OP_MUL;
  assign op_signed = (bus.p3_op == OP_DIVS) || (bus.p3_op == OP_MODS);
  assign op_mod    = (bus.p3_op == OP_MODS) || (bus.p3_op == OP_MODU);

  // A divide only issues from IDLE; in DONE the same op is still in P3 and must not restart.
  assign issue = (state == MDU_IDLE) && op_is_div;

  assign a_mag   = (op_signed && bus.p3_data_a[WIDTH-1]) ? -bus.p3_data_a : bus.p3_data_a;
  assign b_mag   = (op_signed && bus.p3_data_b[WIDTH-1]) ? -bus.p3_data_b : bus.p3_data_b;
  assign product = bus.p3_data_a * bus.p3_data_b;

  cpu_divider_core #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (issue),
    .step      (state == MDU_BUSY),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Sign flags are only latched for signed ops, so unsigned results pass through.
  assign quo_fix     = b_zero_q ? '1 : ((a_neg_q != b_neg_q) ? -quo : quo);
  assign rem_fix     = a_neg_q ? -rem : rem;
  assign final_value = div_mod_q ? rem_fix : quo_fix;

  assign bus.mdu_stall     = issue || (state == MDU_BUSY);
  assign bus.mdu_busy      = state == MDU_BUSY;
  assign bus.p4_mdu_result = p4_result_q;
  assign bus.p4_mdu_valid  = p4_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= MDU_IDLE;
      count       <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      div_mod_q   <= 1'b0;
      p4_result_q <= '0;
      p4_valid_q  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (op_is_div) begin
            a_neg_q   <= op_signed && bus.p3_data_a[WIDTH-1];
            b_neg_q   <= op_signed && bus.p3_data_b[WIDTH-1];
            b_zero_q  <= bus.p3_data_b == '0;
            div_mod_q <= op_mod;
            count     <= CW'(WIDTH - 1);
            state     <= MDU_BUSY;
          end else if (!bus.stall_in) begin
            p4_valid_q <= op_is_mdu;
            if (op_is_mdu) begin
              p4_result_q <= op_is_mul ? product : '0;
            end
          end
        end
        MDU_BUSY: begin
          if (count == '0) begin
            state <= MDU_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        MDU_DONE: begin
          if (!bus.stall_in) begin
            p4_result_q <= final_value;
            p4_valid_q  <= 1'b1;
            state       <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mdu_ctrl.sv
// tb/tb_cpu_mdu_ctrl.sv - randomized and directed checks of cpu_mdu_ctrl against an arithmetic model
module tb_cpu_mdu_ctrl;
  import cpu_mdu_ctrl_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          slo;
    int          shi;
    int          rst_at;
    logic        has_lit;
    logic [31:0] lit;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cpu_mdu_ctrl_if #(.WIDTH(W)) bus ();

  cpu_mdu_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  rec_t recs[$];
  rec_t p3_rec;
  rec_t p4_rec;

  int          age      = 0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_result = '0;
  logic        adv_last = 1'b0;
  logic        m_adv;

  function automatic rec_t mk(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                              int slo, int shi, int rst_at, logic has_lit, logic [31:0] lit);
    rec_t r;
    r.op = op; r.a = a; r.b = b; r.slo = slo; r.shi = shi;
    r.rst_at = rst_at; r.has_lit = has_lit; r.lit = lit;
    return r;
  endfunction

  // Result straight from the arithmetic definition of each op.
  function automatic logic [31:0] ref_result(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op[5:3] != 3'b100) return 32'h0;
    case (op[2:0])
      3'd0: return a * b;
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      3'd5: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      3'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd7: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A divide stalls P3 for WIDTH+1 cycles after it arrives; the pipeline
  // advances on any edge without a stall and hands the P3 op to P4.
  always @(posedge clock) begin
    if (reset) begin
      age      = 0;
      m_valid  = 1'b0;
      m_result = '0;
      adv_last = 1'b0;
    end else begin
      m_adv = !bus.stall_in && !(is_div_op(bus.p3_op) && age < W + 1);
      if (m_adv) begin
        m_valid = is_mdu_op(bus.p3_op);
        if (m_valid) m_result = ref_result(bus.p3_op, bus.p3_data_a, bus.p3_data_b);
        p4_rec = p3_rec;
        age    = 0;
      end else if (age < 1000) begin
        age++;
      end
      adv_last = m_adv;
    end
  end

  initial begin
    rec_t r;
    int   cyc;
    int   stall_cnt;
    logic after_reset;
    logic post_rst;
    logic exp_stall;
    logic exp_busy;
    logic [5:0] rop;

    recs.push_back(mk(OP_MUL,  32'd7,         32'hFFFF_FFFD, -2, -2, -1, 1'b1, 32'hFFFF_FFEB));
    recs.push_back(mk(OP_DIVU, 32'd100,       32'd7,         -2, -2, -1, 1'b1, 32'd14));
    recs.push_back(mk(OP_MODU, 32'd100,       32'd7,         -2, -2, -1, 1'b1, 32'd2));
    recs.push_back(mk(OP_DIVS, -32'd100,      32'd7,         -2, -2, -1, 1'b1, 32'hFFFF_FFF2));
    recs.push_back(mk(OP_MODS, -32'd100,      32'd7,         -2, -2, -1, 1'b1, 32'hFFFF_FFFE));
    recs.push_back(mk(OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, -2, -2, -1, 1'b1, 32'h8000_0000));
    recs.push_back(mk(OP_MODS, 32'h8000_0000, 32'hFFFF_FFFF, -2, -2, -1, 1'b1, 32'h0));
    recs.push_back(mk(OP_DIVU, 32'h1234_5678, 32'h0,         -2, -2, -1, 1'b1, 32'hFFFF_FFFF));
    recs.push_back(mk(OP_MODS, 32'h1234_5678, 32'h0,         -2, -2, -1, 1'b1, 32'h1234_5678));
    recs.push_back(mk(OP_DIVU, 32'd100,       32'd7,          5, 43, -1, 1'b1, 32'd14));
    recs.push_back(mk(OP_DIVU, 32'd100,       32'd7,         -2, -2, 12, 1'b0, 32'h0));
    recs.push_back(mk(6'h00,   32'h0,         32'h0,         -2, -2, -1, 1'b0, 32'h0));
    recs.push_back(mk(OP_DIVU, 32'd9,         32'd3,         -2, -2, -1, 1'b1, 32'd3));
    recs.push_back(mk(OP_MUL,  32'h0001_0000, 32'h0001_0001,  0,  2, -1, 1'b1, 32'h0001_0000));
    recs.push_back(mk(6'h05,   32'd1,         32'd2,         -2, -2, -1, 1'b0, 32'h0));
    recs.push_back(mk(6'h21,   32'd5,         32'd6,         -2, -2, -1, 1'b1, 32'h0));
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rop = OP_MUL;
        2:       rop = {3'b100, 3'($urandom_range(1, 3))};
        3, 4:    rop = OP_DIVS;
        5:       rop = OP_MODS;
        6:       rop = OP_DIVU;
        7:       rop = OP_MODU;
        default: rop = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      endcase
      recs.push_back(mk(rop, rnd_operand(), rnd_operand(), -1, -1, -1, 1'b0, 32'h0));
    end
    recs.push_back(mk(6'h00, 32'h0, 32'h0, -2, -2, -1, 1'b0, 32'h0));
    recs.push_back(mk(6'h00, 32'h0, 32'h0, -2, -2, -1, 1'b0, 32'h0));

    p3_rec        = mk(6'h00, 32'h0, 32'h0, -2, -2, -1, 1'b0, 32'h0);
    p4_rec        = p3_rec;
    r             = p3_rec;
    reset         = 1'b1;
    bus.stall_in  = 1'b0;
    bus.p3_op     = 6'h00;
    bus.p3_data_a = '0;
    bus.p3_data_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_mdu_stall", 32'(bus.mdu_stall), 32'h0);
    chk("reset_mdu_busy", 32'(bus.mdu_busy), 32'h0);
    chk("reset_p4_valid", 32'(bus.p4_mdu_valid), 32'h0);
    chk("reset_p4_result", bus.p4_mdu_result, 32'h0);
    reset       = 1'b0;
    after_reset = 1'b1;
    post_rst    = 1'b0;
    stall_cnt   = 0;
    cyc         = 0;

    while (1) begin
      @(negedge clock);
      if (reset) begin
        reset       = 1'b0;
        after_reset = 1'b1;
        post_rst    = 1'b1;
      end
      if (after_reset || adv_last) begin
        if (adv_last)
          chk("p3_stall_cycles", 32'(stall_cnt), is_div_op(p4_rec.op) ? 32'(W + 1) : 32'h0);
        if (recs.size() == 0) break;
        r             = recs.pop_front();
        p3_rec        = r;
        bus.p3_op     = r.op;
        bus.p3_data_a = r.a;
        bus.p3_data_b = r.b;
        stall_cnt     = 0;
        after_reset   = 1'b0;
      end
      if (r.slo == -1) bus.stall_in = ($urandom_range(0, 3) == 0);
      else             bus.stall_in = (age >= r.slo) && (age <= r.shi);
      if (r.rst_at >= 0 && age == r.rst_at) begin
        reset        = 1'b1;
        bus.stall_in = 1'b0;
      end

      #1;
      exp_stall = is_div_op(bus.p3_op) && (age < W + 1);
      exp_busy  = is_div_op(bus.p3_op) && (age >= 1) && (age <= W);
      chk("mdu_stall", 32'(bus.mdu_stall), 32'(exp_stall));
      chk("mdu_busy", 32'(bus.mdu_busy), 32'(exp_busy));
      chk("p4_mdu_valid", 32'(bus.p4_mdu_valid), 32'(m_valid));
      if (m_valid) chk("p4_mdu_result", bus.p4_mdu_result, m_result);
      if (adv_last && p4_rec.has_lit) chk("literal_result", bus.p4_mdu_result, p4_rec.lit);
      if (post_rst) begin
        chk("post_reset_stall", 32'(bus.mdu_stall), 32'h0);
        chk("post_reset_busy", 32'(bus.mdu_busy), 32'h0);
        chk("post_reset_valid", 32'(bus.p4_mdu_valid), 32'h0);
        post_rst = 1'b0;
      end
      if (bus.mdu_stall) stall_cnt++;

      cyc++;
      if (cyc > 20000) begin
        n_vec++;
        n_miss++;
        $display("FAIL timeout: got %0d cycles expected at most 20000", cyc);
        break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cpu_mdu_ctrl.md
Name: cpu_mdu_ctrl

Overview:
- Controls and sequences the multiply/divide unit (MDU) in execute stage P3 of the 5-stage CPU pipeline.
- Accepts MDU ops issued by decode (op class 3'b100).
- Multiplies finish in a single pipeline step.
- Divides and modulos run on a 32-iteration restoring divider. The pipeline is held via mdu_stall until the divide finishes.
- The result is registered into P4 alongside p4_op, for writeback through the normal P4 path.

Parameters:
- WIDTH, 32, operand and result width. Iteration count equals WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- stall_in  in  1  pipeline stall from other sources (memory stage); excludes mdu_stall
- p3_op  in  6  op currently in P3; MDU ops are 6'b100_xxx
- p3_data_a  in  WIDTH  operand A, after bypass mux
- p3_data_b  in  WIDTH  operand B (register or literal), after bypass mux
- mdu_stall  out  1  hold the pipeline; ORed into the global stall by the parent
- p4_mdu_result  out  WIDTH  MDU result for the instruction now in P4
- p4_mdu_valid  out  1  instruction in P4 is an MDU op; select p4_mdu_result for writeback
- mdu_busy  out  1  divider iterating (debug/perf counter)

Behaviour:
- Op decode on p3_op[2:0] when p3_op[5:3]==3'b100:
  - 0 = MUL (low WIDTH bits of a*b)
  - 1-3 = reserved; result 0, no stall
  - 4 = DIVS, 5 = MODS, 6 = DIVU, 7 = MODU
- Advance edge: any rising edge with global stall low, i.e. !(stall_in || mdu_stall).
- Reset: state IDLE, mdu_stall=0, mdu_busy=0, p4_mdu_result=0, p4_mdu_valid=0, iteration counter=0.
- States:
  - IDLE
    - MUL/reserved op in P3: no stall. On the advance edge, p4_mdu_result <= product (or 0) and p4_mdu_valid <= 1.
    - Divide op in P3: mdu_stall=1 combinationally in that cycle. At the edge (regardless of stall_in), latch |a|, |b|, sign flags, op and a zero-divisor flag; counter <= WIDTH-1; go to BUSY.
    - Non-MDU op: on the advance edge, p4_mdu_valid <= 0.
  - BUSY
    - mdu_stall=1, mdu_busy=1.
    - One restoring step per cycle: shift the remainder/quotient pair, trial subtract, set the quotient bit.
    - When counter==0, go to DONE; otherwise counter-1.
    - Iteration continues even while stall_in=1.
  - DONE
    - mdu_stall=0. The P3 op is still the divide but must NOT restart.
    - Wait here while stall_in=1.
    - On the advance edge: p4_mdu_result <= final value, p4_mdu_valid <= 1, go to IDLE.
- Latency: a divide holds P3 for exactly WIDTH+1 cycles of mdu_stall (issue cycle plus 32 BUSY cycles). Its result appears in P4 one edge after DONE is entered, when stall_in is low.
- Sign fix (signed ops):
  - Quotient negated if sign(a) != sign(b).
  - Remainder takes the sign of a.
  - Negation is two's complement, WIDTH-bit wrap.
- Divide by zero: quotient = all ones (both signed and unsigned); remainder = a unchanged. The full latency still applies (fixed latency).
- Overflow: DIVS of 0x80000000 by 0xFFFFFFFF gives quotient 0x80000000; MODS gives 0.
- Reset mid-divide: immediate return to IDLE, outputs to reset values, partial result discarded.
- stall_in during IDLE with an MUL in P3: p4 registers hold; no state change.
- Back-to-back divides: the second is seen in IDLE only after the first has advanced. No overlap, no bubble added by the MDU.

Decomposition:
- cpu.vh additions:
  - OP_MUL=6'h20, OP_DIVS=6'h24, OP_MODS=6'h25, OP_DIVU=6'h26, OP_MODU=6'h27
  - MDU state encodings MDU_IDLE/MDU_BUSY/MDU_DONE
- Sub-module cpu_divider_core: unsigned restoring datapath with load/step controls, exposing quotient and remainder.
- The FSM, sign handling, multiply and the P4 register stay in cpu_mdu_ctrl.

Test Plan:
- MUL, a=7, b=-3 (0xFFFFFFFD), stall_in=0 -> no mdu_stall; next edge p4_mdu_result=0xFFFFFFEB, p4_mdu_valid=1.
- DIVU, a=100, b=7 -> mdu_stall high for exactly 33 cycles; then p4_mdu_result=14. Repeat as MODU -> 2.
- DIVS, a=-100, b=7 -> 0xFFFFFFF2 (-14). MODS -> 0xFFFFFFFE (-2). DIVS 0x80000000 by -1 -> 0x80000000.
- DIVU and MODS with b=0, a=0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678; latency unchanged.
- DIVU 100/7 with stall_in=1 from BUSY cycle 5 until 10 cycles after DONE is entered -> mdu_stall drops at the normal time; result written only on the first edge with stall_in=0; no restart of the divide.
- Reset asserted at BUSY cycle 12 -> next cycle mdu_stall=0, mdu_busy=0, p4_mdu_valid=0. A subsequent DIVU 9/3 completes normally with result 3.
